kcore_write_back_start_arb: RTL and testbench

Round-robin start scheduler that shares the single write_back dataflow process among NUM_REQ upstream producers. Each producer signals pending work through its own start FIFO (empty_n/read handshake, depth-limited shift-register start FIFO). The arbiter pops one start token, drives the ap_start/ap_ready/ap_done handshake of write_back for that token, reports completions, and counts runs.

---
 rtl/kcore_write_back_start_arb.sv | 146 ++++++++++++++
 tb/tb_kcore_write_back_start_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/kcore_write_back_start_arb.sv
// kcore_write_back_start_arb
//
// Round-robin start scheduler that shares one write_back dataflow process
// among NUM_REQ producers. Each producer queues start tokens in its own start
// FIFO. The arbiter pops one token per run, drives write_back's
// ap_start/ap_ready/ap_done handshake for that token, reports completions and
// counts them.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous, active-high; clears all state
//   enable       1 = new grants allowed; 0 = finish the current run only
//   req_empty_n  bit i set = start FIFO i holds at least one token
//   req_read     one-hot pop strobe to start FIFO i (IDLE only)
//   wb_ap_start  start to write_back (high while in START)
//   wb_ap_ready  write_back accepted the start
//   wb_ap_done   write_back finished the current run
//   wb_src_id    index of the requester currently being served
//   done_vld     one-cycle pulse per completed run
//   done_id      requester index of the completed run (valid with done_vld)
//   run_count    completed runs, wraps modulo 2^CNT_WIDTH
//   proto_err    sticky: wb_ap_done seen in START without wb_ap_ready
module kcore_write_back_start_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_WIDTH  = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_empty_n,
  output logic [NUM_REQ-1:0]   req_read,
  output logic                 wb_ap_start,
  input  logic                 wb_ap_ready,
  input  logic                 wb_ap_done,
  output logic [ID_WIDTH-1:0]  wb_src_id,
  output logic                 done_vld,
  output logic [ID_WIDTH-1:0]  done_id,
  output logic [CNT_WIDTH-1:0] run_count,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic                  found;
  logic                  grant;
  logic                  complete;
  logic                  proto_set;
  logic [2*NUM_REQ-1:0]  req_rot;
  int unsigned           win_sum;

  // Round-robin search: rotate the request vector so rr_ptr lands at bit 0,
  // take the first set bit, then map the offset back to a requester index.
  always_comb begin
    req_rot = {req_empty_n, req_empty_n} >> rr_ptr;
    found   = 1'b0;
    win_sum = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        win_sum = 32'(rr_ptr) + i;
      end
    end
    if (win_sum >= NUM_REQ) begin
      win_sum = win_sum - NUM_REQ;
    end
    winner   = ID_WIDTH'(win_sum);
    next_ptr = (32'(winner) == NUM_REQ - 1) ? '0 : winner + ID_WIDTH'(1);
  end

  assign grant = (state == IDLE) && enable && found;

  always_comb begin
    req_read = '0;
    if (grant) begin
      req_read = NUM_REQ'(1) << winner;
    end
  end

  assign wb_ap_start = (state == START);

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    proto_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          state_next = START;
        end
      end
      START: begin
        if (wb_ap_ready) begin
          complete   = wb_ap_done;
          state_next = wb_ap_done ? IDLE : BUSY;
        end else if (wb_ap_done) begin
          // done before the start was accepted: flag it, keep waiting
          proto_set = 1'b1;
        end
      end
      BUSY: begin
        if (wb_ap_done) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      wb_src_id <= '0;
      done_id   <= '0;
      done_vld  <= 1'b0;
      run_count <= '0;
      proto_err <= 1'b0;
    end else begin
      state    <= state_next;
      done_vld <= complete;
      if (grant) begin
        wb_src_id <= winner;
        rr_ptr    <= next_ptr;
      end
      if (complete) begin
        done_id   <= wb_src_id;
        run_count <= run_count + CNT_WIDTH'(1);
      end
      if (proto_set) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kcore_write_back_start_arb.sv
// Randomized bench for kcore_write_back_start_arb. A transaction-level model
// (token counts per FIFO, "run in progress" / "start accepted" flags, modulo
// round-robin pointer) predicts every output each cycle.
module tb_kcore_write_back_start_arb;

  localparam int unsigned NR = 5;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NR-1:0] req_empty_n;
  logic [NR-1:0] req_read;
  logic          wb_ap_start;
  logic          wb_ap_ready;
  logic          wb_ap_done;
  logic [IW-1:0] wb_src_id;
  logic          done_vld;
  logic [IW-1:0] done_id;
  logic [CW-1:0] run_count;
  logic          proto_err;

  kcore_write_back_start_arb #(
    .NUM_REQ  (NR),
    .ID_WIDTH (IW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_empty_n(req_empty_n),
    .req_read   (req_read),
    .wb_ap_start(wb_ap_start),
    .wb_ap_ready(wb_ap_ready),
    .wb_ap_done (wb_ap_done),
    .wb_src_id  (wb_src_id),
    .done_vld   (done_vld),
    .done_id    (done_id),
    .run_count  (run_count),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  bit          m_busy;
  bit          m_acked;
  bit          m_dv;
  bit          m_err;
  int unsigned m_ptr;
  int unsigned m_src;
  int unsigned m_did;
  int unsigned m_cnt;
  int unsigned tok [NR];
  int unsigned runs_done = 0;

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_acked = 1'b0;
    m_dv    = 1'b0;
    m_err   = 1'b0;
    m_ptr   = 0;
    m_src   = 0;
    m_did   = 0;
    m_cnt   = 0;
  endfunction

  function automatic void model_complete();
    m_busy = 1'b0;
    m_dv   = 1'b1;
    m_did  = m_src;
    m_cnt  = (m_cnt + 1) % (1 << CW);
    runs_done++;
  endfunction

  task automatic check_regs(input string pfx);
    check({pfx, "wb_ap_start"}, 32'(wb_ap_start), 32'(m_busy && !m_acked));
    check({pfx, "wb_src_id"},   32'(wb_src_id),   m_src);
    check({pfx, "done_vld"},    32'(done_vld),    32'(m_dv));
    check({pfx, "done_id"},     32'(done_id),     m_did);
    check({pfx, "run_count"},   32'(run_count),   m_cnt);
    check({pfx, "proto_err"},   32'(proto_err),   32'(m_err));
  endtask

  // mode 0: well-behaved write_back; mode 1: arbitrary ready/done
  task automatic cycle(input int unsigned mode);
    bit            g;
    int unsigned   w;
    int unsigned   idx;
    logic [NR-1:0] exp_rd;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if ($urandom_range(0, 3) == 0 && tok[i] < 3) tok[i]++;
      req_empty_n[i] = (tok[i] != 0);
    end
    enable = ($urandom_range(0, 7) != 0);
    if (mode == 0 && m_busy && !m_acked) begin
      wb_ap_ready = ($urandom_range(0, 2) == 0);
      wb_ap_done  = wb_ap_ready && ($urandom_range(0, 1) == 0);
    end else begin
      wb_ap_ready = ($urandom_range(0, 2) == 0);
      wb_ap_done  = ($urandom_range(0, 2) == 0);
    end
    #1;
    g = 1'b0;
    w = 0;
    if (!m_busy && enable) begin
      for (int unsigned k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (!g && tok[idx] != 0) begin
          g = 1'b1;
          w = idx;
        end
      end
    end
    exp_rd = '0;
    if (g) exp_rd[w] = 1'b1;
    check("req_read", 32'(req_read), 32'(exp_rd));
    check_regs("");
    m_dv = 1'b0;
    if (!m_busy) begin
      if (g) begin
        m_busy  = 1'b1;
        m_acked = 1'b0;
        m_src   = w;
        m_ptr   = (w + 1) % NR;
        tok[w]--;
      end
    end else if (!m_acked) begin
      if (wb_ap_ready) begin
        if (wb_ap_done) model_complete();
        else m_acked = 1'b1;
      end else if (wb_ap_done) begin
        m_err = 1'b1;
      end
    end else if (wb_ap_done) begin
      model_complete();
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    req_empty_n = '0;
    wb_ap_ready = 1'b0;
    wb_ap_done  = 1'b0;
    for (int i = 0; i < NR; i++) tok[i] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_read", 32'(req_read), 32'd0);
    check_regs("rst_");
    @(negedge clk);
    reset = 1'b0;

    repeat (800) cycle(0);
    check("legal_runs_seen", 32'(runs_done > 16), 32'd1);

    // async reset while a run is in flight
    for (int n = 0; n < 60 && !m_busy; n++) cycle(0);
    check("run_in_flight", 32'(m_busy), 32'd1);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    model_reset();
    check("arst_req_read", 32'(req_read), 32'd0);
    check_regs("arst_");
    @(negedge clk);
    #1;
    check_regs("arst_hold_");
    reset = 1'b0;

    repeat (800) cycle(1);
    check("err_seen", 32'(m_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
